// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes on the Signal bus, operand width and
// the IDLE/BUSY/DONE state type used by the sequential multiplier and divider.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] OUT   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Opcode/operand bus between the control unit (master) and the multiplier
// (slave); the 64-bit result returns as {HI, LO} on dataOut.
interface shift_add_multiplier_if;
  import alu_pkg::*;

  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [5:0]         Signal;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;

  modport master (
    output dataA, dataB, Signal,
    input  dataOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal,
    output dataOut, busy, done
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift-add step per clock,
// WIDTH steps per product, result held on dataOut until the next completion.
module shift_add_multiplier
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  shift_add_multiplier_if.slave  bus
);

  alu_state_t         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] data_out_reg;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               last_iter;

  // The 33-bit sum keeps the carry; it becomes the top bit after the shift.
  assign sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {sum, prod[WIDTH-1:1]};
  assign last_iter = (cnt == 6'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mcand        <= '0;
      prod         <= '0;
      cnt          <= '0;
      data_out_reg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Signal == MULTU) begin
            mcand <= bus.dataA;
            prod  <= {{WIDTH{1'b0}}, bus.dataB};
            cnt   <= '0;
            state <= BUSY;
          end else if (state == DONE && bus.Signal == OUT) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          prod <= prod_next;
          cnt  <= cnt + 6'd1;
          if (last_iter) begin
            data_out_reg <= prod_next;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dataOut = data_out_reg;
  assign bus.busy    = (state == BUSY);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: a table of operand/product vectors
// plus hand-written sequences for reset, ignored inputs and back-to-back starts.
module tb_shift_add_multiplier;
  import alu_pkg::*;

  localparam logic [5:0] NOP = 6'b000000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  shift_add_multiplier_if bus();

  shift_add_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents MULTU for one edge; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.dataA  = a;
    bus.dataB  = b;
    bus.Signal = MULTU;
    @(negedge clk);
    bus.Signal = NOP;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles, output bit overlap);
    cycles = 0;
    busy_cycles = 0;
    overlap = 1'b0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cycles++;
      if (bus.busy && bus.done) overlap = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  vec_t vecs[10];
  int cycles, busy_cycles;
  bit overlap;
  logic [63:0] held;

  initial begin
    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,         32'hDEAD_BEEF, 64'h0};
    vecs[3] = '{32'hDEAD_BEEF, 32'd0,         64'h0};
    vecs[4] = '{32'd7,         32'd6,         64'd42};
    vecs[5] = '{32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780};
    vecs[6] = '{32'hDEAD_BEEF, 32'd2,         64'h0000_0001_BD5B_7DDE};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
    vecs[9] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.Signal = NOP;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_dataOut", bus.dataOut, 64'd0);

    // IDLE ignores OUT
    bus.Signal = OUT;
    @(negedge clk);
    bus.Signal = NOP;
    check("idle_out_busy", 64'(bus.busy), 64'd0);
    check("idle_out_done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 10; i++) begin
      held = bus.dataOut;
      start_op(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_start_busy", i), 64'(bus.busy), 64'd1);
      check($sformatf("v%0d_busy_hold", i), bus.dataOut, held);
      wait_done(cycles, busy_cycles, overlap);
      check($sformatf("v%0d_done", i), 64'(bus.done), 64'd1);
      check($sformatf("v%0d_latency", i), 64'(cycles), 64'd32);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cycles), 64'd32);
      check($sformatf("v%0d_overlap", i), 64'(overlap), 64'd0);
      check($sformatf("v%0d_product", i), bus.dataOut, vecs[i].p);
      $display("vec %0d: %h * %h -> %h", i, vecs[i].a, vecs[i].b, bus.dataOut);
      if (i == 0) begin
        // DONE holds under unrelated opcodes
        bus.Signal = DIVU;
        repeat (3) @(negedge clk);
        check("done_hold_divu", 64'(bus.done), 64'd1);
        check("done_hold_busy", 64'(bus.busy), 64'd0);
      end
      bus.Signal = OUT;
      @(negedge clk);
      bus.Signal = NOP;
      check($sformatf("v%0d_out_done", i), 64'(bus.done), 64'd0);
      check($sformatf("v%0d_out_busy", i), 64'(bus.busy), 64'd0);
      check($sformatf("v%0d_out_keep", i), bus.dataOut, vecs[i].p);
    end

    // Reset at iteration 10 abandons the multiply
    start_op(32'h1234_5678, 32'h10);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_dataOut", bus.dataOut, 64'd0);
    start_op(32'd7, 32'd6);
    wait_done(cycles, busy_cycles, overlap);
    check("midrst_next_latency", 64'(cycles), 64'd32);
    check("midrst_next_product", bus.dataOut, 64'd42);
    $display("reset test: 7 * 6 -> %h", bus.dataOut);

    // Signal and operands ignored while busy
    start_op(32'h1234_5678, 32'h10);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      bus.dataA  = $urandom;
      bus.dataB  = $urandom;
      bus.Signal = (cycles % 3 == 0) ? MULTU : ((cycles % 3 == 1) ? OUT : NOP);
      if (cycles == 20) check("ign_hold_old", bus.dataOut, 64'd42);
      @(negedge clk);
      cycles++;
    end
    bus.Signal = NOP;
    check("ign_latency", 64'(cycles), 64'd32);
    check("ign_product", bus.dataOut, 64'h0000_0001_2345_6780);
    $display("ignore test: 12345678 * 10 -> %h", bus.dataOut);

    // Back-to-back: MULTU issued during the DONE cycle
    bus.dataA  = 32'd2;
    bus.dataB  = 32'h8000_0000;
    bus.Signal = MULTU;
    @(negedge clk);
    bus.Signal = NOP;
    check("b2b_done_drop", 64'(bus.done), 64'd0);
    check("b2b_busy_rise", 64'(bus.busy), 64'd1);
    check("b2b_old_kept", bus.dataOut, 64'h0000_0001_2345_6780);
    wait_done(cycles, busy_cycles, overlap);
    check("b2b_latency", 64'(cycles), 64'd32);
    check("b2b_product", bus.dataOut, 64'h0000_0001_0000_0000);
    $display("back-to-back: 2 * 80000000 -> %h", bus.dataOut);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
